mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  - MEM pipeline stage: consumer of the execute-stage outputs (ALUop, MemAddr, store data Result, WriteData, WriteReg, WriteDataNum).
//  - Drives a req/ready data-memory port for lw/sw. Registers writeback fields toward WB. Raises StallReq_o while a memory access is outstanding.
//  - Non-memory ops (ALU, jal/beq/blt link values) pass through with 1-cycle latency.
// PARAMETERS
//  - TIMEOUT_CYCLES  255  max BUSY cycles waiting for dmem_ready before abort; 0 = no timeout
// PORTS
//  - clk             in   1   single clock, rising edge
//  - rst             in   1   synchronous, active-high reset
//  - in_valid        in   1   EX/MEM register holds a valid op
//  - ALUop_i         in   5   op code (lw=5'b10100, sw=5'b10101, others non-memory)
//  - MemAddr_i       in   32  effective address from EX
//  - StoreData_i     in   32  sw data (EX Result)
//  - WriteData_i     in   32  ALU result / link address from EX
//  - WriteDataNum_i  in   5   destination register index
//  - WriteReg_i      in   1   destination write enable
//  - dmem_req_o      out  1   memory request
//  - dmem_we_o       out  1   1 = store, 0 = load
//  - dmem_addr_o     out  32  word address
//  - dmem_wdata_o    out  32  store data
//  - dmem_rdata_i    in   32  load data; valid when dmem_ready_i=1
//  - dmem_ready_i    in   1   access complete this cycle
//  - out_valid_o     out  1   WB fields valid (1-cycle pulse per op)
//  - WriteReg_o      out  1   WB register write enable
//  - WriteDataNum_o  out  5   WB destination index
//  - WriteData_o     out  32  WB data
//  - StallReq_o      out  1   freeze IF..EX stages
//  - mem_err_o       out  1   1-cycle pulse on timeout (or misaligned access, see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE, timeout count 0, every output 0.
//  - FSM IDLE:
//    - in_valid & non-mem op: register fields, out_valid_o=1 next cycle, stay IDLE.
//    - in_valid & lw/sw: latch addr/data/we/rd, go BUSY. No out_valid_o.
//  - FSM BUSY:
//    - dmem_req_o=1; we/addr/wdata held stable until ready.
//    - On dmem_ready_i=1: go IDLE, dmem_req_o=0 next cycle, out_valid_o=1 next cycle.
//      - lw: WriteData_o = dmem_rdata_i.
//      - sw: WriteData_o = 0, WriteReg_o = 0.
//  - StallReq_o (combinational) = (IDLE & in_valid & is_mem) | (BUSY & ~dmem_ready_i).
//    - It drops in the ready cycle, so the next op is accepted on the following edge.
//  - Latency: non-mem 1 cycle; lw/sw = N+2 cycles, N = BUSY cycles before ready (min 2).
//  - WriteReg_o is forced 0 when WriteDataNum_i==0 (x0) and for sw.
//  - Timeout (TIMEOUT_CYCLES>0):
//    - Counter clears on BUSY entry and increments each BUSY cycle without ready.
//    - At TIMEOUT_CYCLES-1 with no ready: next cycle state IDLE, dmem_req_o=0, mem_err_o=1, out_valid_o=1, WriteReg_o=0.
//    - Ready and the timeout in the same cycle: ready wins, no error.
//  - in_valid is ignored while BUSY; the upstream stage is stalled then.
//  - rst asserted mid-access: abort at the next edge, dmem_req_o=0, no writeback; any late ready is ignored in IDLE.
// CONFIGURATION
//  - MEM_ALIGN_CHECK_EN defined:
//    - lw/sw with MemAddr_i[1:0]!=0 never enters BUSY and issues no request.
//    - Next cycle: mem_err_o=1, out_valid_o=1, WriteReg_o=0.
//  - MEM_ALIGN_CHECK_EN undefined: dmem_addr_o = {MemAddr_i[31:2],2'b00}; the access proceeds and mem_err_o comes only from timeout.
// STRUCTURE
//  - Shared package riscv_pipe_pkg holds:
//    - ALUop localparams: OP_JAL, OP_BEQ, OP_BLT, OP_LW, OP_SW, OP_ADD, etc.
//    - MEM FSM state encoding: IDLE=1'b0, BUSY=1'b1.
//  - One sub-module, mem_timeout_cnt: clear/enable/expire counter, width $clog2(TIMEOUT_CYCLES+1).
// TESTING
//  - add, WriteData_i=32'h5, rd=3, in_valid 1 cycle -> next cycle out_valid_o=1, WriteData_o=5, WriteReg_o=1, StallReq_o=0.
//  - lw addr 32'h100, ready after 3 BUSY cycles, rdata 32'hDEADBEEF -> dmem_req_o high 3 cycles, StallReq_o high 3 cycles, WriteData_o=DEADBEEF, WriteReg_o=1.
//  - sw addr 32'h104, data 32'h12, ready in first BUSY cycle -> dmem_we_o=1, wdata=12, out_valid_o after 2 cycles, WriteReg_o=0.
//  - TIMEOUT_CYCLES=4, lw, ready never asserted -> req high 4 cycles, then mem_err_o pulse, WriteReg_o=0, state IDLE.
//  - lw, rst asserted in 2nd BUSY cycle, ready 1 cycle later -> req=0 after edge, no out_valid_o, no error.
//  - MEM_ALIGN_CHECK_EN defined, lw addr 32'h102 -> no dmem_req_o, mem_err_o=1 next cycle; undefined -> dmem_addr_o=32'h100.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: ALU op codes, MEM-stage FSM encoding and op helpers.
package riscv_pipe_pkg;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_XOR = 5'b00100;
  localparam logic [4:0] OP_SLT = 5'b00101;
  localparam logic [4:0] OP_BEQ = 5'b10000;
  localparam logic [4:0] OP_BLT = 5'b10001;
  localparam logic [4:0] OP_JAL = 5'b10010;
  localparam logic [4:0] OP_LW  = 5'b10100;
  localparam logic [4:0] OP_SW  = 5'b10101;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ready port between the MEM stage (master) and the memory (slave).
interface mem_access_stage_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ready_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    input  dmem_rdata_i, dmem_ready_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    output dmem_rdata_i, dmem_ready_i
  );
endinterface

// File: rtl/mem_access_stage_timeout_cnt.sv
// Clear/enable wait counter; expire is asserted in the last allowed wait cycle.
module mem_timeout_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (LIMIT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam int unsigned W = $clog2(LIMIT + 1);
      localparam logic [W-1:0] LAST = W'(LIMIT - 1);
      logic [W-1:0] cnt;

      always_ff @(posedge clk) begin
        if (rst || clear) begin
          cnt <= '0;
        end else if (enable) begin
          cnt <= cnt + W'(1);
        end
      end

      assign expire = enable && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues lw/sw on the dmem port, registers writeback fields, stalls upstream.
// Optional MEM_ALIGN_CHECK_EN: misaligned lw/sw are rejected with mem_err_o instead of issued.
module mem_access_stage
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [4:0]                ALUop_i,
  input  logic [31:0]               MemAddr_i,
  input  logic [31:0]               StoreData_i,
  input  logic [31:0]               WriteData_i,
  input  logic [4:0]                WriteDataNum_i,
  input  logic                      WriteReg_i,
  mem_access_stage_if.master        dmem,
  output logic                      out_valid_o,
  output logic                      WriteReg_o,
  output logic [4:0]                WriteDataNum_o,
  output logic [31:0]               WriteData_o,
  output logic                      StallReq_o,
  output logic                      mem_err_o
);

  logic [0:0]  state;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic        wr_q;
  logic        is_mem;
  logic        misaligned;
  logic        go_busy;
  logic        expire;

  always_comb begin
    is_mem = is_mem_op(ALUop_i);
`ifdef MEM_ALIGN_CHECK_EN
    misaligned = (MemAddr_i[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
    go_busy    = (state == IDLE) && in_valid && is_mem && !misaligned;
    // A rejected misaligned op completes in one cycle, so it must not freeze upstream.
    StallReq_o = go_busy || ((state == BUSY) && !dmem.dmem_ready_i);
  end

  mem_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .enable ((state == BUSY) && !dmem.dmem_ready_i),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rd_q           <= '0;
      wr_q           <= 1'b0;
      out_valid_o    <= 1'b0;
      WriteReg_o     <= 1'b0;
      WriteDataNum_o <= '0;
      WriteData_o    <= '0;
      mem_err_o      <= 1'b0;
    end else begin
      out_valid_o <= 1'b0;
      mem_err_o   <= 1'b0;
      if (state == IDLE) begin
        if (in_valid) begin
          if (!is_mem) begin
            out_valid_o    <= 1'b1;
            WriteReg_o     <= WriteReg_i && (WriteDataNum_i != '0);
            WriteDataNum_o <= WriteDataNum_i;
            WriteData_o    <= WriteData_i;
          end else if (misaligned) begin
            out_valid_o    <= 1'b1;
            mem_err_o      <= 1'b1;
            WriteReg_o     <= 1'b0;
            WriteDataNum_o <= WriteDataNum_i;
            WriteData_o    <= '0;
          end else begin
            state   <= BUSY;
            we_q    <= (ALUop_i == OP_SW);
            addr_q  <= MemAddr_i & 32'hFFFF_FFFC;
            wdata_q <= StoreData_i;
            rd_q    <= WriteDataNum_i;
            wr_q    <= (ALUop_i == OP_LW) && WriteReg_i && (WriteDataNum_i != '0);
          end
        end
      end else begin
        if (dmem.dmem_ready_i) begin
          state          <= IDLE;
          out_valid_o    <= 1'b1;
          WriteReg_o     <= wr_q;
          WriteDataNum_o <= rd_q;
          WriteData_o    <= we_q ? '0 : dmem.dmem_rdata_i;
        end else if (expire) begin
          state          <= IDLE;
          out_valid_o    <= 1'b1;
          mem_err_o      <= 1'b1;
          WriteReg_o     <= 1'b0;
          WriteDataNum_o <= rd_q;
          WriteData_o    <= '0;
        end
      end
    end
  end

  assign dmem.dmem_req_o   = (state == BUSY);
  assign dmem.dmem_we_o    = we_q;
  assign dmem.dmem_addr_o  = addr_q;
  assign dmem.dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a writeback scoreboard (TIMEOUT_CYCLES=4).
module tb_mem_access_stage;
  import riscv_pipe_pkg::*;

  typedef struct packed {
    logic        err;
    logic        wreg;
    logic [4:0]  num;
    logic [31:0] data;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  ALUop_i;
  logic [31:0] MemAddr_i;
  logic [31:0] StoreData_i;
  logic [31:0] WriteData_i;
  logic [4:0]  WriteDataNum_i;
  logic        WriteReg_i;
  logic        out_valid_o;
  logic        WriteReg_o;
  logic [4:0]  WriteDataNum_o;
  logic [31:0] WriteData_o;
  logic        StallReq_o;
  logic        mem_err_o;

  int unsigned checks = 0;
  int unsigned failures = 0;
  wb_t exp_q[$];

  mem_access_stage_if dmem ();

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .ALUop_i        (ALUop_i),
    .MemAddr_i      (MemAddr_i),
    .StoreData_i    (StoreData_i),
    .WriteData_i    (WriteData_i),
    .WriteDataNum_i (WriteDataNum_i),
    .WriteReg_i     (WriteReg_i),
    .dmem           (dmem),
    .out_valid_o    (out_valid_o),
    .WriteReg_o     (WriteReg_o),
    .WriteDataNum_o (WriteDataNum_o),
    .WriteData_o    (WriteData_o),
    .StallReq_o     (StallReq_o),
    .mem_err_o      (mem_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] wdata, input logic [4:0] rd, input logic wreg);
    in_valid       = 1'b1;
    ALUop_i        = op;
    MemAddr_i      = addr;
    StoreData_i    = sdata;
    WriteData_i    = wdata;
    WriteDataNum_i = rd;
    WriteReg_i     = wreg;
    #1;
  endtask

  always @(negedge clk) begin
    if (out_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_err", {31'd0, mem_err_o}, {31'd0, e.err});
        chk("wb_wreg", {31'd0, WriteReg_o}, {31'd0, e.wreg});
        chk("wb_num", {27'd0, WriteDataNum_o}, {27'd0, e.num});
        chk("wb_data", WriteData_o, e.data);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; ALUop_i = '0; MemAddr_i = '0; StoreData_i = '0;
    WriteData_i = '0; WriteDataNum_i = '0; WriteReg_i = 1'b0;
    dmem.dmem_ready_i = 1'b0; dmem.dmem_rdata_i = '0;
    step(); step();
    chk("rst_req", {31'd0, dmem.dmem_req_o}, 32'd0);
    chk("rst_we", {31'd0, dmem.dmem_we_o}, 32'd0);
    chk("rst_addr", dmem.dmem_addr_o, 32'd0);
    chk("rst_wdata", dmem.dmem_wdata_o, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_wb_data", WriteData_o, 32'd0);
    chk("rst_stall", {31'd0, StallReq_o}, 32'd0);
    chk("rst_err", {31'd0, mem_err_o}, 32'd0);
    rst = 1'b0;

    // add passthrough, then back-to-back x0 write and jal link
    drive(OP_ADD, 32'h0, 32'h0, 32'h5, 5'd3, 1'b1);
    chk("add_stall", {31'd0, StallReq_o}, 32'd0);
    exp_q.push_back('{1'b0, 1'b1, 5'd3, 32'h5});
    step();
    chk("add_out_valid", {31'd0, out_valid_o}, 32'd1);
    drive(OP_ADD, 32'h0, 32'h0, 32'h77, 5'd0, 1'b1);
    exp_q.push_back('{1'b0, 1'b0, 5'd0, 32'h77});
    step();
    drive(OP_JAL, 32'h0, 32'h0, 32'h40, 5'd1, 1'b1);
    exp_q.push_back('{1'b0, 1'b1, 5'd1, 32'h40});
    step();
    in_valid = 1'b0;
    step();
    chk("idle_out_valid", {31'd0, out_valid_o}, 32'd0);

    // lw, ready in third BUSY cycle; upstream holds the op while stalled
    drive(OP_LW, 32'h100, 32'h0, 32'h0, 5'd7, 1'b1);
    chk("lw_stall_accept", {31'd0, StallReq_o}, 32'd1);
    chk("lw_req_accept", {31'd0, dmem.dmem_req_o}, 32'd0);
    exp_q.push_back('{1'b0, 1'b1, 5'd7, 32'hDEADBEEF});
    step();
    chk("lw_req_b1", {31'd0, dmem.dmem_req_o}, 32'd1);
    chk("lw_we_b1", {31'd0, dmem.dmem_we_o}, 32'd0);
    chk("lw_addr_b1", dmem.dmem_addr_o, 32'h100);
    chk("lw_stall_b1", {31'd0, StallReq_o}, 32'd1);
    step();
    chk("lw_req_b2", {31'd0, dmem.dmem_req_o}, 32'd1);
    chk("lw_stall_b2", {31'd0, StallReq_o}, 32'd1);
    step();
    chk("lw_req_b3", {31'd0, dmem.dmem_req_o}, 32'd1);
    dmem.dmem_ready_i = 1'b1; dmem.dmem_rdata_i = 32'hDEADBEEF;
    #1;
    chk("lw_stall_ready", {31'd0, StallReq_o}, 32'd0);
    step();
    dmem.dmem_ready_i = 1'b0; in_valid = 1'b0;
    #1;
    chk("lw_req_done", {31'd0, dmem.dmem_req_o}, 32'd0);
    chk("lw_out_valid", {31'd0, out_valid_o}, 32'd1);
    step();

    // sw, ready in first BUSY cycle
    drive(OP_SW, 32'h104, 32'h12, 32'h0, 5'd9, 1'b1);
    exp_q.push_back('{1'b0, 1'b0, 5'd9, 32'h0});
    step();
    chk("sw_req", {31'd0, dmem.dmem_req_o}, 32'd1);
    chk("sw_we", {31'd0, dmem.dmem_we_o}, 32'd1);
    chk("sw_addr", dmem.dmem_addr_o, 32'h104);
    chk("sw_wdata", dmem.dmem_wdata_o, 32'h12);
    chk("sw_out_valid_early", {31'd0, out_valid_o}, 32'd0);
    dmem.dmem_ready_i = 1'b1; dmem.dmem_rdata_i = 32'h5555_5555;
    #1;
    chk("sw_stall_ready", {31'd0, StallReq_o}, 32'd0);
    step();
    dmem.dmem_ready_i = 1'b0; in_valid = 1'b0;
    #1;
    chk("sw_out_valid", {31'd0, out_valid_o}, 32'd1);
    chk("sw_req_done", {31'd0, dmem.dmem_req_o}, 32'd0);
    step();

    // timeout: ready never comes, request held four cycles
    drive(OP_LW, 32'h200, 32'h0, 32'h0, 5'd5, 1'b1);
    exp_q.push_back('{1'b1, 1'b0, 5'd5, 32'h0});
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req_%0d", i), {31'd0, dmem.dmem_req_o}, 32'd1);
      step();
    end
    chk("to_req_done", {31'd0, dmem.dmem_req_o}, 32'd0);
    chk("to_err", {31'd0, mem_err_o}, 32'd1);
    chk("to_stall", {31'd0, StallReq_o}, 32'd0);
    step();
    chk("to_err_pulse", {31'd0, mem_err_o}, 32'd0);

    // ready coincides with the timeout cycle: ready wins
    drive(OP_LW, 32'h208, 32'h0, 32'h0, 5'd6, 1'b1);
    exp_q.push_back('{1'b0, 1'b1, 5'd6, 32'h0BAD_F00D});
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    dmem.dmem_ready_i = 1'b1; dmem.dmem_rdata_i = 32'h0BAD_F00D;
    step();
    dmem.dmem_ready_i = 1'b0;
    chk("race_no_err", {31'd0, mem_err_o}, 32'd0);
    step();

    // reset in the second BUSY cycle, late ready afterwards
    drive(OP_LW, 32'h300, 32'h0, 32'h0, 5'd8, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_req", {31'd0, dmem.dmem_req_o}, 32'd0);
    chk("rst_mid_out_valid", {31'd0, out_valid_o}, 32'd0);
    dmem.dmem_ready_i = 1'b1; dmem.dmem_rdata_i = 32'h1234_5678;
    step();
    dmem.dmem_ready_i = 1'b0;
    chk("late_ready_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("late_ready_err", {31'd0, mem_err_o}, 32'd0);
    step();

    // misaligned lw
    drive(OP_LW, 32'h102, 32'h0, 32'h0, 5'd4, 1'b1);
`ifdef MEM_ALIGN_CHECK_EN
    exp_q.push_back('{1'b1, 1'b0, 5'd4, 32'h0});
    step();
    in_valid = 1'b0;
    chk("mis_no_req", {31'd0, dmem.dmem_req_o}, 32'd0);
    chk("mis_err", {31'd0, mem_err_o}, 32'd1);
    step();
`else
    exp_q.push_back('{1'b0, 1'b1, 5'd4, 32'hCAFE});
    step();
    in_valid = 1'b0;
    chk("mis_req", {31'd0, dmem.dmem_req_o}, 32'd1);
    chk("mis_addr", dmem.dmem_addr_o, 32'h100);
    dmem.dmem_ready_i = 1'b1; dmem.dmem_rdata_i = 32'hCAFE;
    step();
    dmem.dmem_ready_i = 1'b0;
    chk("mis_out_valid", {31'd0, out_valid_o}, 32'd1);
    step();
`endif

    step(); step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
